// File: rtl/pc_stack.sv
// Program counter with PC-relative branch and a LIFO return-address stack for call/ret.
// Optional macro PC_TRAP_EN: stack overflow/underflow redirect the PC to TRAP_VECTOR.
module pc_stack #(
   parameter int              WIDTH        = 16,
   parameter int              OFFSET_WIDTH = 8,
   parameter int              DEPTH        = 8,
   parameter longint unsigned TRAP_VECTOR  = 0
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic        [WIDTH-1:0]        in,
   input  logic signed [OFFSET_WIDTH-1:0] offset,
   input  logic                           clear,
   input  logic                           jump,
   input  logic                           call,
   input  logic                           ret,
   input  logic                           branch,
   input  logic                           inc,
   output logic        [WIDTH-1:0]        out,
   output logic        [$clog2(DEPTH):0]  depth,
   output logic                           empty,
   output logic                           full,
   output logic                           overflow,
   output logic                           underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;

   if (WIDTH < 4 || OFFSET_WIDTH > WIDTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("pc_stack: illegal WIDTH/OFFSET_WIDTH/DEPTH combination");
   end
   if (WIDTH < 64) begin : g_trap_range
      if (TRAP_VECTOR >= (64'd1 << WIDTH)) begin : g_bad_trap
         $error("pc_stack: TRAP_VECTOR does not fit in WIDTH bits");
      end
   end

   function automatic logic [WIDTH-1:0] pc_plus_one(input logic [WIDTH-1:0] pc);
      return pc + WIDTH'(1);
   endfunction

   function automatic logic [WIDTH-1:0] pc_branch(input logic [WIDTH-1:0]        pc,
                                                  input logic signed [OFFSET_WIDTH-1:0] off);
      logic signed [WIDTH-1:0] disp;
      disp = WIDTH'(off);
      return pc + $unsigned(disp);
   endfunction

   logic [WIDTH-1:0] stack [DEPTH];
   logic [WIDTH-1:0] top;
   logic [WIDTH-1:0] ovf_pc;
   logic [WIDTH-1:0] unf_pc;
   logic             do_call;
   logic             do_ret;
   logic             push;
   logic             pop;

   // Lower-priority commands are masked so they cause no stack or flag side effects.
   assign do_call = call & ~clear & ~jump;
   assign do_ret  = ret  & ~clear & ~jump & ~call;
   assign push    = do_call & ~full;
   assign pop     = do_ret  & ~empty;

   assign empty = (depth == '0);
   assign full  = (depth == DW'(DEPTH));
   assign top   = stack[AW'(depth - 1'b1)];

`ifdef PC_TRAP_EN
   localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VECTOR);
   assign ovf_pc = TRAP_PC;
   assign unf_pc = TRAP_PC;
`else
   assign ovf_pc = in;
   assign unf_pc = out;
`endif

   always_ff @(posedge clock) begin
      if (push) begin
         stack[AW'(depth)] <= pc_plus_one(out);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out       <= '0;
         depth     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         out <= '0;
      end else if (jump) begin
         out <= in;
      end else if (do_call) begin
         if (push) begin
            out   <= in;
            depth <= depth + 1'b1;
         end else begin
            out      <= ovf_pc;
            overflow <= 1'b1;
         end
      end else if (do_ret) begin
         if (pop) begin
            out   <= top;
            depth <= depth - 1'b1;
         end else begin
            out       <= unf_pc;
            underflow <= 1'b1;
         end
      end else if (branch) begin
         out <= pc_branch(out, offset);
      end else if (inc) begin
         out <= pc_plus_one(out);
      end
   end

endmodule

// File: tb/tb_pc_stack.sv
// Directed bench for pc_stack: queue-based reference model checked every cycle plus literal expectations.
module tb_pc_stack;

   localparam int W  = 16;
   localparam int D  = 8;
   localparam int TV = 0;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic [W-1:0]       in = '0;
   logic signed [7:0]  offset = '0;
   logic               clear = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0, branch = 1'b0, inc = 1'b0;
   logic [W-1:0]       out;
   logic [3:0]         depth;
   logic               empty, full, overflow, underflow;

   int total = 0;
   int bad   = 0;

   pc_stack #(.WIDTH(W), .OFFSET_WIDTH(8), .DEPTH(D), .TRAP_VECTOR(TV)) dut (
      .clock(clock), .reset(reset), .in(in), .offset(offset),
      .clear(clear), .jump(jump), .call(call), .ret(ret), .branch(branch), .inc(inc),
      .out(out), .depth(depth), .empty(empty), .full(full),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference model: PC as an integer modulo 2^16, return stack as a queue.
   int m_pc;
   int stk[$];
   bit m_ovf, m_unf;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_pc = 0; stk.delete(); m_ovf = 0; m_unf = 0;
      end else if (clear) m_pc = 0;
      else if (jump) m_pc = int'(in);
      else if (call) begin
         if (stk.size() < D) begin
            stk.push_back((m_pc + 1) % 65536);
            m_pc = int'(in);
         end else begin
            m_ovf = 1;
`ifdef PC_TRAP_EN
            m_pc = TV;
`else
            m_pc = int'(in);
`endif
         end
      end else if (ret) begin
         if (stk.size() > 0) m_pc = stk.pop_back();
         else begin
            m_unf = 1;
`ifdef PC_TRAP_EN
            m_pc = TV;
`endif
         end
      end else if (branch) m_pc = (m_pc + int'(offset) + 65536) % 65536;
      else if (inc) m_pc = (m_pc + 1) % 65536;
   end

   always @(negedge clock) begin
      if (reset === 1'b1) begin
         chk("model out", out, m_pc);
         chk("model depth", depth, stk.size());
         chk("model empty", empty, stk.size() == 0);
         chk("model full", full, stk.size() == D);
         chk("model overflow", overflow, m_ovf);
         chk("model underflow", underflow, m_unf);
      end
   end

   task automatic step(input bit c, j, ca, r, b, i, input logic [W-1:0] a, input logic signed [7:0] o);
      clear = c; jump = j; call = ca; ret = r; branch = b; inc = i; in = a; offset = o;
      @(posedge clock); #1;
   endtask

   task automatic do_inc();                      step(0,0,0,0,0,1,'0,'0); endtask
   task automatic do_jump(input logic [W-1:0] a); step(0,1,0,0,0,0,a,'0);  endtask
   task automatic do_call(input logic [W-1:0] a); step(0,0,1,0,0,0,a,'0);  endtask
   task automatic do_ret();                      step(0,0,0,1,0,0,'0,'0); endtask
   task automatic do_branch(input logic signed [7:0] o); step(0,0,0,0,1,0,'0,o); endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] exp_pc;
      repeat (2) @(posedge clock);
      #1;
      chk("reset out", out, 0);
      chk("reset depth", depth, 0);
      chk("reset empty", empty, 1);
      chk("reset full", full, 0);
      chk("reset overflow", overflow, 0);
      chk("reset underflow", underflow, 0);
      @(negedge clock) reset = 1'b1;

      // Increment from zero
      do_inc(); chk("t1 out1", out, 16'h0001);
      do_inc(); chk("t1 out2", out, 16'h0002);
      do_inc(); chk("t1 out3", out, 16'h0003);
      chk("t1 depth", depth, 0);
      chk("t1 empty", empty, 1);

      // Wraparound on inc and negative branch
      do_jump(16'hFFFF); chk("t2 jump", out, 16'hFFFF);
      do_inc();          chk("t2 wrap", out, 16'h0000);
      do_branch(8'shFE); chk("t2 branch", out, 16'hFFFE);

      // Nested call/return
      do_jump(16'h0010);
      do_call(16'h0200); chk("t3 call1", out, 16'h0200); chk("t3 d1", depth, 1);
      do_call(16'h0300); chk("t3 call2", out, 16'h0300); chk("t3 d2", depth, 2);
      do_ret();          chk("t3 ret1", out, 16'h0201);  chk("t3 d3", depth, 1);
      do_ret();          chk("t3 ret2", out, 16'h0011);  chk("t3 d4", depth, 0);

      // Fill the stack, overflow it, then drain it
      do_jump(16'h1000);
      for (int k = 0; k < 8; k++) do_call(16'h2000 + 16'(k * 16));
      chk("t4 full", full, 1);
      chk("t4 depth8", depth, 8);
      chk("t4 ovf before", overflow, 0);
      do_call(16'h3000);
`ifdef PC_TRAP_EN
      chk("t4 ovf out", out, TV);
`else
      chk("t4 ovf out", out, 16'h3000);
`endif
      chk("t4 overflow", overflow, 1);
      chk("t4 depth kept", depth, 8);
      for (int j = 0; j < 8; j++) begin
         do_ret();
         exp_pc = (j < 7) ? 16'(16'h2061 - 16 * j) : 16'h1001;
         chk("t4 ret addr", out, exp_pc);
      end
      chk("t4 empty", empty, 1);

      // Underflow, then clear keeps the sticky flag
      do_jump(16'h0042);
      do_ret();
`ifdef PC_TRAP_EN
      chk("t5 unf out", out, TV);
`else
      chk("t5 unf out", out, 16'h0042);
`endif
      chk("t5 underflow", underflow, 1);
      step(1,0,0,0,0,0,'0,'0);
      chk("t5 clear out", out, 0);
      chk("t5 unf sticky", underflow, 1);
      chk("t5 ovf sticky", overflow, 1);

      // Reset during an in-flight call
      do_jump(16'h0555);
      clear = 0; jump = 0; call = 1; in = 16'h1234;
      #2 reset = 1'b0;
      #1;
      chk("rst mid out", out, 0);
      chk("rst mid depth", depth, 0);
      chk("rst mid ovf", overflow, 0);
      chk("rst mid unf", underflow, 0);
      call = 0;
      @(negedge clock) reset = 1'b1;

      // Priority among simultaneous commands
      do_jump(16'h0050);
      do_call(16'h0100); chk("t6 call", depth, 1);
      step(1,1,1,1,0,1,16'h0ABC,'0);
      chk("t6 all out", out, 0);
      chk("t6 all depth", depth, 1);
      chk("t6 all ovf", overflow, 0);
      chk("t6 all unf", underflow, 0);
      step(0,1,1,0,0,0,16'h0777,'0);
      chk("t6 jc out", out, 16'h0777);
      chk("t6 jc depth", depth, 1);
      step(0,0,0,1,1,1,'0,8'sh10);
      chk("t6 ret wins", out, 16'h0051);
      chk("t6 ret depth", depth, 0);
      step(0,0,0,0,0,0,16'hFFFF,8'sh10);
      chk("t6 hold", out, 16'h0051);
      do_branch(8'sh10); chk("t6 branch fwd", out, 16'h0061);
      step(0,0,0,0,0,0,'0,'0);
      @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for the CPU fetch path. Next generation of the 16-bit jump/inc/reset counter.
- Adds configurable width, signed PC-relative branch, and subroutine call/return backed by an internal return-address stack (LIFO).
- Reports stack status and sticky error flags to the control unit.
- Drives the instruction-memory address directly from a register; no combinational path from inputs to `out`.

Parameters:
- WIDTH, 16, PC/address width in bits (≥4).
- OFFSET_WIDTH, 8, width of the signed branch offset (≤ WIDTH).
- DEPTH, 8, return-stack entries (power of 2, ≥2).
- TRAP_VECTOR, 0, address loaded on a stack error when PC_TRAP_EN is defined.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in  input  WIDTH  absolute target for jump/call.
- offset  input  OFFSET_WIDTH  signed two's-complement branch displacement.
- clear  input  1  synchronous clear of PC to 0 (stack untouched).
- jump  input  1  load `in`.
- call  input  1  push return address, load `in`.
- ret  input  1  pop return address into PC.
- branch  input  1  PC ← PC + sext(offset).
- inc  input  1  PC ← PC + 1.
- out  output  WIDTH  current PC.
- depth  output  $clog2(DEPTH)+1  number of valid stack entries.
- empty  output  1  depth == 0.
- full  output  1  depth == DEPTH.
- overflow  output  1  sticky: a call was issued while full.
- underflow  output  1  sticky: a ret was issued while empty.

Behaviour:
- **Reset.** reset low (async): out=0, depth=0, overflow=0, underflow=0, stack contents don't-care. Outputs are therefore empty=1, full=0.
- **Latency.** All updates take effect on the rising clock edge, so `out` changes one cycle after a command. Status outputs are registered or decoded from registered depth only.
- **Command priority per cycle.** Exactly one command is acted on; all lower-priority commands that cycle are ignored entirely, with no stack or flag side effects:
  clear > jump > call > ret > branch > inc > hold.
- **clear:** out ← 0. Stack, depth and flags are unchanged.
- **jump:** out ← in.
- **call:**
  - Not full: push (out+1) mod 2^WIDTH, depth+1, out ← in.
  - Full: out ← in, no push, depth unchanged, overflow ← 1.
- **ret:**
  - Not empty: out ← top entry, depth−1.
  - Empty: out unchanged, underflow ← 1.
- **branch:** out ← (out + sign-extended offset) mod 2^WIDTH. Wraps in both directions.
- **inc:** out ← (out + 1) mod 2^WIDTH. All-ones wraps to 0.
- **hold:** no command asserted; all state is unchanged.
- **Sticky flags.** overflow and underflow clear only on reset; clear does not affect them.
- **Stack storage.** Register array indexed by depth. The top entry is array[depth−1].
- **Call immediately after call.** Nested calls push successive return addresses correctly, with no bubble required.
- **Reset mid-operation.** Any in-flight command is discarded; state is as at reset.

Optional Feature:
- Macro: PC_TRAP_EN.
- **Defined:**
  - Call while full: out ← TRAP_VECTOR instead of `in`.
  - Ret while empty: out ← TRAP_VECTOR instead of holding.
  - overflow/underflow are still set; stack behaviour is otherwise identical.
- **Undefined:** behaviour exactly as in Behaviour; TRAP_VECTOR is unused.

Test Plan:
1. reset low, then release; inc for 3 cycles -> out = 0,1,2,3; empty=1, depth=0.
2. WIDTH=16, jump in=0xFFFF, then inc -> out=0xFFFF then 0x0000. Then branch offset=8'hFE -> out=0xFFFE.
3. out=0x0010, call in=0x0200; call in=0x0300; ret; ret ->
   - out: 0x0200, 0x0300, 0x0201, 0x0011.
   - depth: 1, 2, 1, 0.
4. DEPTH=8, nine calls -> full=1 after the 8th. The 9th sets overflow=1 and out=in (or TRAP_VECTOR with PC_TRAP_EN). depth stays 8; 8 rets return the correct addresses.
5. Empty stack, out=0x0042, ret -> out stays 0x0042 (TRAP_VECTOR with PC_TRAP_EN), underflow=1. A later clear leaves underflow=1 and sets out=0.
6. clear, jump, call, ret, inc all asserted in the same cycle -> out=0, depth unchanged, no flags set. jump+call together -> out=in, no push.
